mem_arbiter: RTL

Two-port memory arbiter that shares the single external memory bus between the `rcpu` core (port 0) and a DMA/peripheral master (port 1). It accepts each master's `RE`/`WE` request, grants one at a time, drives the external memory handshake, and returns a one-cycle `Ready` strobe to the owner. Each master sees a `memReady`-style interface, so the core's stall logic (`!memReady && memRE`) works unchanged. A per-transaction watchdog aborts accesses the memory never acknowledges.

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: rcpu core (port 0) and DMA (port 1) share one bus.
// Build option: MEMARB_ROUND_ROBIN_EN selects round-robin on conflicts.
module mem_arbiter #(
  parameter int N       = 32,
  parameter int M       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cpuAddr,
  input  logic [M-1:0] cpuWData,
  input  logic         cpuRE,
  input  logic         cpuWE,
  output logic         cpuReady,
  output logic [M-1:0] cpuRData,
  input  logic [N-1:0] dmaAddr,
  input  logic [M-1:0] dmaWData,
  input  logic         dmaRE,
  input  logic         dmaWE,
  output logic         dmaReady,
  output logic [M-1:0] dmaRData,
  output logic [N-1:0] memAddr,
  output logic [M-1:0] memWrite,
  output logic         memRE,
  output logic         memWE,
  input  logic         memAck,
  input  logic [M-1:0] memRead,
  output logic         grant,
  output logic         busy,
  output logic         busErr
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LP_LIM = 8'(TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_grant;
  logic [7:0] r_wdog;

  logic w_cpuReq;
  logic w_dmaReq;
  logic w_anyReq;
  logic w_busy;
  logic w_win;
  logic w_sel;
  logic w_act;
  logic w_ack;
  logic w_tmo;
  logic w_done;
  logic w_sre;
  logic w_swe;
  logic [M-1:0] w_rdata;

`ifdef MEMARB_ROUND_ROBIN_EN
  logic r_last;
`endif

  assign w_cpuReq = cpuRE | cpuWE;
  assign w_dmaReq = dmaRE | dmaWE;
  assign w_anyReq = w_cpuReq | w_dmaReq;
  assign w_busy   = (r_state == BUSY);

  // Pick the IDLE-cycle winner among the requesting ports
  always_comb begin
    w_win = 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
    if (w_cpuReq && w_dmaReq)
      w_win = ~r_last;
    else
      w_win = w_dmaReq;
`else
    w_win = ~w_cpuReq & w_dmaReq;
`endif
  end

  // Owner in BUSY is the registered grant; in IDLE the fresh winner
  assign w_sel  = w_busy ? r_grant : w_win;
  assign w_act  = rst & (w_busy | w_anyReq);
  assign w_ack  = w_act & memAck;
  assign w_tmo  = rst & w_busy & (r_wdog == LP_LIM) & ~memAck;
  assign w_done = w_ack | w_tmo;
  assign w_sre  = w_sel ? dmaRE : cpuRE;
  assign w_swe  = w_sel ? dmaWE : cpuWE;

  // Route the owner's request onto the memory bus; write beats read
  always_comb begin
    memAddr  = '0;
    memWrite = '0;
    memRE    = 1'b0;
    memWE    = 1'b0;
    if (w_act) begin
      memAddr  = w_sel ? dmaAddr : cpuAddr;
      memWrite = w_sel ? dmaWData : cpuWData;
      memWE    = ~w_tmo & w_swe;
      memRE    = ~w_tmo & w_sre & ~w_swe;
    end
  end

  // Completion data: memory data on ack, all-ones on abort
  always_comb begin
    w_rdata = '0;
    if (w_ack)
      w_rdata = memRead;
    else if (w_tmo)
      w_rdata = '1;
  end

  assign cpuReady = w_done & ~w_sel;
  assign dmaReady = w_done & w_sel;
  assign cpuRData = w_rdata;
  assign dmaRData = w_rdata;
  assign grant    = r_grant;
  assign busy     = w_busy;
  assign busErr   = w_tmo;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // Next state: zero-wait acks complete without leaving IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_anyReq && !memAck) w_next = BUSY;
      BUSY: if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grant capture and watchdog count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant <= 1'b0;
      r_wdog  <= '0;
    end else if (!w_busy) begin
      r_wdog <= '0;
      if (w_anyReq)
        r_grant <= w_win;
    end else if (!memAck) begin
      r_wdog <= r_wdog + 8'd1;
    end
  end

`ifdef MEMARB_ROUND_ROBIN_EN
  // Remember the last winner so conflicts alternate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_last <= 1'b1;
    else if (!w_busy && w_anyReq)
      r_last <= w_win;
  end
`endif

endmodule
